// File: rtl/gate_response_checker_if.sv
// Stimulus/response bundle between a gate-test driver and gate_response_checker.
interface gate_response_checker_if #(
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic             sample;
  logic             in1;
  logic             in2;
  logic             out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       coverage;
  logic             first_err_valid;
  logic [1:0]       first_err_idx;
  logic             timeout;

  modport master (
    output start, sample, in1, in2, out,
    input  busy, done, pass, err_count, coverage, first_err_valid, first_err_idx, timeout
  );

  modport slave (
    input  start, sample, in1, in2, out,
    output busy, done, pass, err_count, coverage, first_err_valid, first_err_idx, timeout
  );
endinterface

// File: rtl/gate_response_checker.sv
// Checks sampled 2-input gate responses against TRUTH_TABLE and tracks combination coverage.
// Optional CHECKER_TIMEOUT_EN adds a CHECK-state cycle limit that forces a failing DONE.
module gate_response_checker #(
  parameter logic [3:0]  TRUTH_TABLE = 4'b1110,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  gate_response_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Parameter sanity: a zero-width counter or sub-2 limit makes no sense.
  if (ERR_W < 1) begin : g_bad_err_w
    $error("gate_response_checker: ERR_W must be at least 1");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("gate_response_checker: TIMEOUT must be at least 2");
  end

  state_t           state_q;
  logic [ERR_W-1:0] err_q;
  logic [3:0]       cov_q;
  logic             fev_q;
  logic [1:0]       fei_q;

  logic [1:0]       idx_c;
  logic [3:0]       hit_c;
  logic             mismatch_c;
  logic             cov_full_c;
  logic [ERR_W-1:0] err_d;

  always_comb begin
    idx_c      = {bus.in1, bus.in2};
    hit_c      = 4'b0001 << idx_c;
    mismatch_c = (bus.out != TRUTH_TABLE[idx_c]);
    cov_full_c = ((cov_q | hit_c) == 4'hF);
    err_d      = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + ERR_W'(1);
  end

`ifdef CHECKER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             to_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= '0;
      cov_q   <= 4'h0;
      fev_q   <= 1'b0;
      fei_q   <= 2'b00;
`ifdef CHECKER_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else if (bus.start) begin
      // Start from any state opens a fresh run; a coincident sample is dropped.
      state_q <= CHECK;
      err_q   <= '0;
      cov_q   <= 4'h0;
      fev_q   <= 1'b0;
      fei_q   <= 2'b00;
`ifdef CHECKER_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        CHECK: begin
          if (bus.sample) begin
            cov_q <= cov_q | hit_c;
            if (mismatch_c) begin
              err_q <= err_d;
              if (!fev_q) begin
                fev_q <= 1'b1;
                fei_q <= idx_c;
              end
            end
          end
`ifdef CHECKER_TIMEOUT_EN
          cnt_q <= cnt_q + CNT_W'(1);
          // Completion on the limit cycle takes priority over the timeout.
          if (bus.sample && cov_full_c) begin
            state_q <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q <= DONE;
            to_q    <= 1'b1;
          end
`else
          if (bus.sample && cov_full_c) begin
            state_q <= DONE;
          end
`endif
        end
        DONE:    state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic to_c;
`ifdef CHECKER_TIMEOUT_EN
  assign to_c = to_q;
`else
  assign to_c = 1'b0;
`endif

  assign bus.busy            = (state_q == CHECK);
  assign bus.done            = (state_q == DONE);
  assign bus.pass            = (state_q == DONE) && (err_q == '0) && !to_c;
  assign bus.err_count       = err_q;
  assign bus.coverage        = cov_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_idx   = fei_q;
  assign bus.timeout         = to_c;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed self-checking bench for gate_response_checker (default OR table, plus an ERR_W=2 copy).
module tb_gate_response_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sample = 1'b0;
  logic in1 = 1'b0;
  logic in2 = 1'b0;
  logic out = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gate_response_checker_if #(.ERR_W(8)) if_a ();
  gate_response_checker_if #(.ERR_W(2)) if_s ();

  assign if_a.start  = start;
  assign if_a.sample = sample;
  assign if_a.in1    = in1;
  assign if_a.in2    = in2;
  assign if_a.out    = out;
  assign if_s.start  = start;
  assign if_s.sample = sample;
  assign if_s.in1    = in1;
  assign if_s.in2    = in2;
  assign if_s.out    = out;

  gate_response_checker #(.TRUTH_TABLE(4'b1110), .ERR_W(8), .TIMEOUT(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  gate_response_checker #(.TRUTH_TABLE(4'b1110), .ERR_W(2), .TIMEOUT(8)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (if_s.slave)
  );

  task automatic step(input logic s, input logic smp, input logic a, input logic b, input logic o);
    start  = s;
    sample = smp;
    in1    = a;
    in2    = b;
    out    = o;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic busy, input logic done, input logic pass,
                         input logic [7:0] err, input logic [3:0] cov, input logic fev,
                         input logic [1:0] fei, input logic to);
    chk({tag, ".busy"}, 32'(if_a.busy), 32'(busy));
    chk({tag, ".done"}, 32'(if_a.done), 32'(done));
    chk({tag, ".pass"}, 32'(if_a.pass), 32'(pass));
    chk({tag, ".err"},  32'(if_a.err_count), 32'(err));
    chk({tag, ".cov"},  32'(if_a.coverage), 32'(cov));
    chk({tag, ".fev"},  32'(if_a.first_err_valid), 32'(fev));
    chk({tag, ".fei"},  32'(if_a.first_err_idx), 32'(fei));
    chk({tag, ".to"},   32'(if_a.timeout), 32'(to));
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    chk_all("reset", 0, 0, 0, 8'd0, 4'h0, 0, 2'd0, 0);
    chk("reset.sat_err", 32'(if_s.err_count), 32'd0);
    rst = 1'b0;

    // Sample in IDLE is ignored
    step(0, 1, 1, 1, 0);
    chk_all("idle_sample", 0, 0, 0, 8'd0, 4'h0, 0, 2'd0, 0);

    // Test 1: clean OR run; coincident sample with start is dropped
    step(1, 1, 1, 1, 0);
    chk_all("t1_start", 1, 0, 0, 8'd0, 4'h0, 0, 2'd0, 0);
    step(0, 1, 0, 0, 0);
    chk("t1_cov1", 32'(if_a.coverage), 32'h1);
    step(0, 1, 0, 1, 1);
    step(0, 1, 1, 0, 1);
    chk("t1_cov7", 32'(if_a.coverage), 32'h7);
    chk("t1_busy", 32'(if_a.busy), 32'd1);
    step(0, 1, 1, 1, 1);
    chk_all("t1_done", 0, 1, 1, 8'd0, 4'hF, 0, 2'd0, 0);
    step(0, 1, 0, 0, 1);
    chk_all("t1_hold", 0, 1, 1, 8'd0, 4'hF, 0, 2'd0, 0);

    // Test 2: 10 observed low
    step(1, 0, 0, 0, 0);
    chk_all("t2_start", 1, 0, 0, 8'd0, 4'h0, 0, 2'd0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1);
    step(0, 1, 1, 0, 0);
    chk("t2_err_mid", 32'(if_a.err_count), 32'd1);
    step(0, 1, 1, 1, 1);
    chk_all("t2_done", 0, 1, 0, 8'd1, 4'hF, 1, 2'd2, 0);

    // Test 3: repeats, partial coverage, then completion
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    chk_all("t3_part", 1, 0, 0, 8'd0, 4'h3, 0, 2'd0, 0);
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 1, 1);
    chk_all("t3_done", 0, 1, 1, 8'd0, 4'hF, 0, 2'd0, 0);

    // Test 4: five wrong 11 samples; ERR_W=2 copy saturates at 3
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0);
    chk("t4_sat_err", 32'(if_s.err_count), 32'd3);
    chk("t4_sat_fei", 32'(if_s.first_err_idx), 32'd3);
    chk("t4_sat_fev", 32'(if_s.first_err_valid), 32'd1);
    chk("t4_sat_done", 32'(if_s.done), 32'd0);
    chk("t4_sat_cov", 32'(if_s.coverage), 32'h8);
    chk("t4_wide_err", 32'(if_a.err_count), 32'd5);

    // Test 5: restart with coincident sample, then synchronous reset mid-run
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    chk_all("t5_pre", 1, 0, 0, 8'd1, 4'h3, 1, 2'd1, 0);
    step(1, 1, 1, 1, 0);
    chk_all("t5_restart", 1, 0, 0, 8'd0, 4'h0, 0, 2'd0, 0);
    step(0, 1, 0, 0, 1);
    chk_all("t5_after", 1, 0, 0, 8'd1, 4'h1, 1, 2'd0, 0);
    rst = 1'b1;
    step(1, 1, 1, 0, 0);
    rst = 1'b0;
    chk_all("t5_rst", 0, 0, 0, 8'd0, 4'h0, 0, 2'd0, 0);
    step(0, 0, 0, 0, 0);
    chk("t5_idle", 32'(if_a.busy), 32'd0);

    // Test 6: only 00 sampled
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
    chk_all("t6_cyc7", 1, 0, 0, 8'd0, 4'h1, 0, 2'd0, 0);
    step(0, 1, 0, 0, 0);
`ifdef CHECKER_TIMEOUT_EN
    chk_all("t6_timeout", 0, 1, 0, 8'd0, 4'h1, 0, 2'd0, 1);
`else
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
    chk_all("t6_cyc20", 1, 0, 0, 8'd0, 4'h1, 0, 2'd0, 0);
`endif

    // Completion on the cycle the limit would hit: coverage wins
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1);
    step(0, 1, 1, 0, 1);
    chk("tie_busy", 32'(if_a.busy), 32'd1);
    step(0, 1, 1, 1, 1);
    chk_all("tie_done", 0, 1, 1, 8'd0, 4'hF, 0, 2'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
Synthesizable response checker for the 2-input gate library. It is the receiving end of the exhaustive stimulus sequence that drives each gate with 00, 01, 10 and 11. It observes the gate's inputs and output on a sample strobe and compares each observation against a parameterized truth table. It tracks which input combinations have been covered, counts mismatches, and reports pass/fail once all four combinations have been checked.

Parameters:
TRUTH_TABLE, 4'b1110, expected output per combination; bit index = {in1,in2}. Default is OR: 00->0, 01->1, 10->1, 11->1.
ERR_W, 8, width of the mismatch counter.
TIMEOUT, 64, cycles allowed in CHECK before forced failure. Used only with CHECKER_TIMEOUT_EN.

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  begin or restart a check run
sample  input  1  strobe: in1/in2/out are valid this cycle
in1  input  1  gate input 1 as driven
in2  input  1  gate input 2 as driven
out  input  1  gate output observed
busy  output  1  high in CHECK
done  output  1  high in DONE
pass  output  1  high in DONE when err_count==0 and no timeout
err_count  output  ERR_W  mismatches this run, saturating
coverage  output  4  bit k set once combination k={in1,in2} has been sampled
first_err_valid  output  1  at least one mismatch this run
first_err_idx  output  2  combination index of the first mismatch
timeout  output  1  run ended by timeout (constant 0 when feature compiled out)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All state is registered.
- Reset values: state=IDLE; busy=0, done=0, pass=0, err_count=0, coverage=4'h0, first_err_valid=0, first_err_idx=2'b00, timeout=0.
- Reset mid-run: on the rising edge with rst=1, return to IDLE and clear everything, regardless of start or sample.
- FSM states: IDLE, CHECK, DONE.
- IDLE:
  - start=1 -> CHECK; clear err_count, coverage, first_err_*, timeout.
  - sample is ignored, including a sample in the same cycle as start.
- CHECK:
  - sample=1: idx={in1,in2}; coverage[idx]<=1.
  - If out != TRUTH_TABLE[idx]: err_count<=err_count+1, saturating at all-ones.
  - On the first mismatch of the run, latch first_err_idx<=idx and set first_err_valid<=1. Later mismatches do not change first_err_*.
  - Repeated samples of an already-covered combination are still compared and counted; coverage is unchanged.
  - When (coverage | onehot(idx)) == 4'hF on a sample edge -> DONE at that same edge.
  - start=1 in CHECK restarts: counters and coverage clear and state stays CHECK. A sample in that cycle is discarded (start wins).
- DONE:
  - done=1 and pass=(err_count==0 && !timeout). Outputs hold.
  - sample is ignored.
  - start=1 -> CHECK with a full clear.
- Latency: a sample at edge N is visible on err_count, coverage and first_err_* after edge N. done and pass are visible after the edge of the covering sample. No combinational path from inputs to outputs.
- Outputs are decoded from registered state and counters only.
- Width rules: err_count wraps never; it saturates. idx is exactly 2 bits.

Optional Feature:
- Macro: CHECKER_TIMEOUT_EN.
- Defined:
  - A cycle counter of width clog2(TIMEOUT+1) clears on entry to CHECK and increments each cycle in CHECK.
  - When it reaches TIMEOUT-1 without full coverage: -> DONE with timeout=1, pass=0.
  - If the final covering sample lands in the same cycle as the timeout, coverage completion wins and timeout=0.
- Not defined: no counter exists; timeout is tied 0; CHECK waits indefinitely.

Test Plan:
1. Default OR table; start, then samples 00/0, 01/1, 10/1, 11/1 on consecutive cycles -> after 4th edge done=1, pass=1, err_count=0, coverage=F, first_err_valid=0.
2. Same sequence but 10 observed with out=0 -> done=1, pass=0, err_count=1, first_err_valid=1, first_err_idx=2.
3. Samples 00, 00, 01, 01 (all correct) -> coverage=3, busy=1, done=0, err_count=0; then 10, 11 -> done=1, pass=1.
4. ERR_W=2; five wrong samples of 11 (out=0) -> err_count=3 (saturated), first_err_idx=3, done=0.
5. After two samples, start and sample together -> coverage=0, err_count=0, still CHECK; rst asserted mid-run -> all outputs at reset values next cycle, state IDLE.
6. With CHECKER_TIMEOUT_EN and TIMEOUT=8; start, then only 00 sampled -> done=1, timeout=1, pass=0 exactly 8 cycles after entering CHECK. Without the macro -> still busy at cycle 20.
